// File: rtl/rr_reg_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rr_reg_arbiter
// Description : Round-robin arbiter that loads one shared DWIDTH register
//               from N_REQ requesters and blocks further grants for HOLD_CYC
//               cycles after every capture.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_reg_arbiter #(
   parameter  int N_REQ    = 4,
   parameter  int DWIDTH   = 8,
   parameter  int HOLD_CYC = 2,
   localparam int IDW      = $clog2(N_REQ)
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*DWIDTH-1:0] i_data,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [DWIDTH-1:0]       o_q,
   output logic                    o_valid,
   output logic [IDW-1:0]          o_owner,
   output logic                    o_busy
);

   localparam logic [3:0]     c_hold_init = 4'(HOLD_CYC);
   localparam logic [IDW-1:0] c_last_idx  = IDW'(N_REQ - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [IDW-1:0]      r_ptr;
   logic [N_REQ-1:0]    r_gnt;
   logic [DWIDTH-1:0]   r_q;
   logic                r_valid;
   logic [IDW-1:0]      r_owner;

   state_t              w_state_nxt;
   logic [3:0]          w_cnt_nxt;
   logic [IDW-1:0]      w_ptr_nxt;
   logic [N_REQ-1:0]    w_gnt_nxt;
   logic [DWIDTH-1:0]   w_q_nxt;
   logic                w_valid_nxt;
   logic [IDW-1:0]      w_owner_nxt;

   logic                w_any;
   logic                w_hi_any;
   logic [IDW-1:0]      w_hi_win;
   logic [IDW-1:0]      w_lo_win;
   logic [IDW-1:0]      w_winner;
   logic [DWIDTH-1:0]   w_sel_data;

   // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      w_any    = 1'b0;
      w_hi_any = 1'b0;
      w_hi_win = '0;
      w_lo_win = '0;
      for (int n = N_REQ - 1; n >= 0; n--) begin
         if (i_req[n]) begin
            w_any    = 1'b1;
            w_lo_win = IDW'(n);
            if (n >= int'(r_ptr)) begin
               w_hi_any = 1'b1;
               w_hi_win = IDW'(n);
            end
         end
      end
      w_winner = w_hi_any ? w_hi_win : w_lo_win;
   end

   always_comb begin
      w_sel_data = '0;
      for (int n = 0; n < N_REQ; n++) begin
         if (w_winner == IDW'(n)) begin
            w_sel_data = i_data[n*DWIDTH +: DWIDTH];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = '0;
      w_q_nxt     = r_q;
      w_valid_nxt = 1'b0;
      w_owner_nxt = r_owner;
      case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_q_nxt     = w_sel_data;
               w_gnt_nxt   = N_REQ'(1) << w_winner;
               w_valid_nxt = 1'b1;
               w_owner_nxt = w_winner;
               w_ptr_nxt   = (w_winner == c_last_idx) ? '0 : w_winner + 1'b1;
               if (c_hold_init != 4'd0) begin
                  w_state_nxt = ST_BUSY;
                  w_cnt_nxt   = c_hold_init;
               end
            end
         end
         ST_BUSY: begin
            // Requests seen here are dropped, never queued.
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_q     <= '0;
         r_valid <= 1'b0;
         r_owner <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_q     <= w_q_nxt;
         r_valid <= w_valid_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   assign o_gnt   = r_gnt;
   assign o_q     = r_q;
   assign o_valid = r_valid;
   assign o_owner = r_owner;
   assign o_busy  = (r_state == ST_BUSY);

endmodule
`default_nettype wire
